alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU with valid/ready handshakes and status flags; next generation of the 8-op combinational alu.
//  Adds registered results, NZCV flags, shifts/compares, sequential multiply and illegal-op reporting.
//  Sits between operand-fetch and writeback; one operation in flight at a time.
// PARAMETERS
//  WIDTH   32  operand/result width (>=8, power of 2)
//  MUL_EN  1   1: op MUL implemented; 0: MUL treated as illegal
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept; transfer when in_valid&&in_ready
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift amount = b[$clog2(WIDTH)-1:0])
//  op         in   4      opcode (alu_pkg)
//  out_valid  out  1      result/flags valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  flags      out  4      {N,Z,C,V}, registered with result
//  out_err    out  1      op was illegal
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, result=0, flags=0, out_err=0; in_ready=1 after reset release.
//  Opcodes: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT(signed),9 SLTU,10 MUL(low WIDTH bits), 11-15 illegal.
//  FSM IDLE->(accept single-cycle op)->DONE; IDLE->(accept MUL)->BUSY->(WIDTH iterations)->DONE;
//   DONE->(out_ready)->IDLE, or DONE->DONE/BUSY if a new op is accepted the same cycle.
//  in_ready = (state==IDLE) || (state==DONE && out_ready); 0 in BUSY.
//  Latency: single-cycle ops: out_valid 1 cycle after accept edge; MUL: WIDTH+1 cycles after accept.
//  Back-to-back single-cycle ops at 1/cycle when out_ready held 1.
//  While out_valid&&!out_ready: result, flags, out_err stable.
//  Operands captured at accept; later changes on a/b/op are ignored.
//  Flags: N=result[WIDTH-1]; Z=(result==0); C,V only for ADD/SUB, else 0.
//   ADD: C=carry-out, V=signed overflow. SUB: C=1 when a>=b unsigned (no borrow), V=signed overflow.
//  SLT/SLTU: result = {WIDTH-1 zeros, lt}. SRA replicates sign bit.
//  Illegal op (incl. MUL when MUL_EN=0): single-cycle completion, result=0, flags=0, out_err=1.
//  Reset asserted mid-MUL: abort immediately, all outputs to reset values, no stale out_valid after release.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_ADD..OP_MUL), state encoding (ST_IDLE/ST_BUSY/ST_DONE), flag bit indices.
//  Sub-module alu_mul_seq: shift-add multiplier (start, a, b -> done pulse, product low WIDTH bits),
//   iteration counter of $clog2(WIDTH)+1 bits; instantiated only when MUL_EN=1.
//  Top: FSM, output registers, combinational single-cycle datapath.
// TESTING (WIDTH=32)
//  ADD a=0x552AAAAC b=0xAB169569 -> result 0x00414015, flags N0 Z0 C1 V0, out_valid next cycle.
//  AND same operands -> 0x01028028, flags 0000; SUB a=5 b=7 -> 0xFFFFFFFE, N1 Z0 C0 V0.
//  ADD 0x7FFFFFFF+1 -> 0x80000000, N1 V1; SRA a=0x80000000 b=36 -> 0xF8000000 (shamt 4).
//  MUL 0x00010003*5 -> 0x0005000F, out_valid exactly 33 cycles after accept, in_ready=0 throughout BUSY.
//  out_ready=0 for 5 cycles after SUB result -> result/flags stable, in_ready=0; op=13 -> result 0, out_err=1.
//  rst_n pulsed low at cycle 10 of MUL -> out_valid=0, result=0 immediately; next ADD 2+3 -> 5 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside the {N,Z,C,V} flags vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add sequential multiplier: one partial product per cycle, low WIDTH bits kept.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_nxt;

  // done and product are combinational on the last iteration so the caller
  // can register the product on the same edge that finishes the multiply.
  always_comb begin
    acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o    = run_q && (cnt_q == LAST);
    product_o = acc_nxt;

    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start_i) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
    end else if (run_q) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops register their result on the accept edge,
// MUL runs through the sequential multiplier; one operation in flight.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             out_err
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic             accept, is_mul, illegal, mul_start, mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   add_full, sub_full;
  logic [SHW-1:0]   shamt;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    shamt    = b[SHW-1:0];
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow; C means no borrow
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = ~sub_full[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  assign is_mul   = (op == OP_MUL) && MUL_EN;
  assign illegal  = (op > OP_MUL) || ((op == OP_MUL) && !MUL_EN);
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
        if (accept) begin
          if (is_mul) begin
            mul_start   = 1'b1;
            out_valid_d = 1'b0;
            state_d     = ST_BUSY;
          end else begin
            result_d    = illegal ? '0 : alu_res;
            flags_d     = illegal ? 4'b0000 : mk_flags(alu_res, alu_c, alu_v);
            err_d       = illegal;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          result_d    = mul_prod;
          flags_d     = mk_flags(mul_prod, 1'b0, 1'b0);
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done),
        .product_o (mul_prod)
      );
    end else begin : g_nomul
      logic unused_mul_start;
      assign unused_mul_start = mul_start;
      assign mul_done         = 1'b0;
      assign mul_prod         = '0;
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scenario bench for alu_mc: expectations queued at issue, checked at each output handshake.
module tb_alu_mc;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         out_err;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: {N,Z,C,V}; overflow detected by widening to 64-bit signed
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, ss;
    logic [63:0] p;
    int          sh;
    e  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    case (o)
      4'd0: begin e.r = x + y; e.f[1] = (e.r < x); ss = sx + sy; e.f[0] = (ss != longint'($signed(e.r))); end
      4'd1: begin e.r = x - y; e.f[1] = (x >= y);  ss = sx - sy; e.f[0] = (ss != longint'($signed(e.r))); end
      4'd2: e.r = x & y;
      4'd3: e.r = x | y;
      4'd4: e.r = x ^ y;
      4'd5: e.r = x << sh;
      4'd6: e.r = x >> sh;
      4'd7: e.r = (x >> sh) | (x[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd8: e.r = {31'b0, (sx < sy)};
      4'd9: e.r = {31'b0, (x < y)};
      4'd10: begin p = {32'b0, x} * {32'b0, y}; e.r = p[31:0]; end
      default: e.e = 1'b1;
    endcase
    if (!e.e) begin
      e.f[3] = e.r[W-1];
      e.f[2] = (e.r == 0);
    end
    return e;
  endfunction

  // Scoreboard: every output transfer is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: result=%h flags=%b err=%b, required no output", result, flags, out_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({result, flags, out_err} !== {e.r, e.f, e.e}) begin
          errors++;
          $display("FAIL sb_data: result=%h flags=%b err=%b, required result=%h flags=%b err=%b",
                   result, flags, out_err, e.r, e.f, e.e);
        end
      end
    end
  end

  // Presents one op, holds it until accepted, then scrambles the inputs.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int t;
    in_valid = 1'b1; op = o; a = x; b = y;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, result, flags, out_err} !== {1'b0, 32'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b result=%h flags=%b err=%b, required all 0", out_valid, result, flags, out_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    sb.push_back('{r: 32'h0041_4015, f: 4'b0010, e: 1'b0});
    issue(4'd0, 32'h552A_AAAC, 32'hAB16_9569);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_latency: out_valid=%b one cycle after accept, required 1", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_consumed: out_valid=%b after handshake, required 0", out_valid);
    end
    sb.push_back('{r: 32'h0102_8028, f: 4'b0000, e: 1'b0});
    issue(4'd2, 32'h552A_AAAC, 32'hAB16_9569); drain();
    sb.push_back('{r: 32'hFFFF_FFFE, f: 4'b1000, e: 1'b0});
    issue(4'd1, 32'd5, 32'd7); drain();
    sb.push_back('{r: 32'h8000_0000, f: 4'b1001, e: 1'b0});
    issue(4'd0, 32'h7FFF_FFFF, 32'd1); drain();
    sb.push_back('{r: 32'hF800_0000, f: 4'b1000, e: 1'b0});
    issue(4'd7, 32'h8000_0000, 32'd36); drain();
    sb.push_back('{r: 32'h0000_0000, f: 4'b0110, e: 1'b0});
    issue(4'd1, 32'h1234_5678, 32'h1234_5678); drain();
  endtask

  task automatic test_mul();
    int lat;
    int busy_bad;
    sb.push_back('{r: 32'h0005_000F, f: 4'b0000, e: 1'b0});
    issue(4'd10, 32'h0001_0003, 32'd5);
    lat = 1; busy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL mul_latency: out_valid after %0d cycles, required 33", lat);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL mul_busy_ready: in_ready high in %0d busy cycles, required 0", busy_bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    sb.push_back('{r: 32'hFFFF_FFFE, f: 4'b1000, e: 1'b0});
    issue(4'd1, 32'd5, 32'd7);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 32'hFFFF_FFFE, 4'b1000}) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles (valid=%b ready=%b result=%h), required 0", bad, out_valid, in_ready, result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    sb.push_back('{r: 32'h0, f: 4'b0000, e: 1'b1});
    issue(4'd13, 32'hDEAD_BEEF, 32'h1);
    checks++;
    if ({out_valid, out_err} !== 2'b11) begin
      errors++;
      $display("FAIL illegal_flag: valid=%b err=%b, required 1 1", out_valid, out_err);
    end
    @(posedge clk); #1;
    sb.push_back('{r: 32'h0, f: 4'b0000, e: 1'b1});
    issue(4'd15, 32'h1, 32'h1); drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [4];
    int         miss;
    ops[0] = 4'd0; ops[1] = 4'd4; ops[2] = 4'd9; ops[3] = 4'd5;
    out_ready = 1'b1;
    miss = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op = ops[i]; a = $urandom; b = $urandom;
      sb.push_back(model(op, a, b));
      @(posedge clk); #1;
      if (out_valid !== 1'b1) miss++;
    end
    in_valid = 1'b0;
    checks++;
    if (miss != 0) begin
      errors++;
      $display("FAIL b2b_rate: %0d cycles without output, required 0", miss);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0]   o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15)); x = $urandom; y = $urandom;
      if (i % 5 == 0) x = 32'h8000_0000;
      sb.push_back(model(o, x, y));
      issue(o, x, y);
      drain();
    end
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    issue(4'd10, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, flags, out_err} !== {1'b0, 32'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL midmul_reset: valid=%b result=%h flags=%b err=%b, required all 0", out_valid, result, flags, out_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) stale++;
      @(posedge clk); #1;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midmul_stale: out_valid high %0d cycles after release, required 0", stale);
    end
    sb.push_back('{r: 32'd5, f: 4'b0000, e: 1'b0});
    issue(4'd0, 32'd2, 32'd3);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd5) begin
      errors++;
      $display("FAIL post_reset_add: valid=%b result=%h, required 1 00000005", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d results never produced, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
